// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares the single data-memory port between two requesters:
//     M0 - CPU load/store path
//     M1 - UART debug/loader path of the com controller
//   A fixed three-state sequencer (IDLE -> ACCESS -> DONE) serves one access
//   at a time. A winner is picked in IDLE, its request is latched into the
//   mem_* registers, memory is accessed for exactly one cycle, and the
//   winner gets a one-cycle done pulse with the captured read data.
//   Memory-mapped I/O decoding is left to the logic downstream of mem_*.
//
// Parameters:
//   AW - address width
//   DW - data width
//   RR - 1: round-robin between requesters, 0: fixed priority with M1 winning
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   m0_req/we/size/addr/wdata  CPU request (req held until m0_done)
//   m0_done, m0_rdata       CPU completion pulse and read data
//   m1_req/we/size/addr/wdata  debug requester, same meaning as M0
//   m1_done, m1_rdata       debug completion pulse and read data
//   m1_lock                 M1 keeps priority while it is the last owner
//   mem_we, mem_size        dmem write size code / load size code
//   mem_addr, mem_wdata     dmem address / write data
//   mem_rdata               dmem combinational read data
//   owner                   last/current granted requester (0 = M0, 1 = M1)
//   busy                    sequencer is not in IDLE
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter bit RR = 1'b1
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          m0_req,
   input  logic [1:0]    m0_we,
   input  logic [2:0]    m0_size,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_done,
   output logic [DW-1:0] m0_rdata,

   input  logic          m1_req,
   input  logic [1:0]    m1_we,
   input  logic [2:0]    m1_size,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_done,
   output logic [DW-1:0] m1_rdata,
   input  logic          m1_lock,

   output logic [1:0]    mem_we,
   output logic [2:0]    mem_size,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,

   output logic          owner,
   output logic          busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next_state;

   logic [1:0]    r_mem_we;
   logic [2:0]    r_mem_size;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_m0_done;
   logic          r_m1_done;
   logic [DW-1:0] r_m0_rdata;
   logic [DW-1:0] r_m1_rdata;
   logic          r_owner;
   logic          r_busy;

   logic          w_grant;
   logic          w_winner;

   // ------------------------------------------------------------------------
   // Arbitration: only meaningful while IDLE. With a single requester it
   // simply wins. With both requesting, a locked M1 that owned the port last
   // keeps it; otherwise round-robin hands the port to the requester that
   // did not have it last, and fixed priority always favours M1.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      w_winner = r_owner;
      if (m0_req && m1_req) begin
         if (m1_lock && r_owner)
            w_winner = 1'b1;
         else if (RR)
            w_winner = ~r_owner;
         else
            w_winner = 1'b1;
      end else begin
         w_winner = m1_req;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (m0_req || m1_req) begin
               w_grant      = 1'b1;
               w_next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: w_next_state = ST_DONE;
         ST_DONE:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         // Registered copy of (state != IDLE), aligned with r_state.
         r_busy  <= (w_next_state != ST_IDLE);
      end
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_we    <= '0;
         r_mem_size  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_m0_done   <= 1'b0;
         r_m1_done   <= 1'b0;
         r_m0_rdata  <= '0;
         r_m1_rdata  <= '0;
         r_owner     <= 1'b0;
      end else begin
         // Done pulses last exactly one cycle unless re-armed below.
         r_m0_done <= 1'b0;
         r_m1_done <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  // Latch the winner's request; later changes on its
                  // address/data inputs do not affect this access.
                  r_owner <= w_winner;
                  if (w_winner) begin
                     r_mem_we    <= m1_we;
                     r_mem_size  <= m1_size;
                     r_mem_addr  <= m1_addr;
                     r_mem_wdata <= m1_wdata;
                  end else begin
                     r_mem_we    <= m0_we;
                     r_mem_size  <= m0_size;
                     r_mem_addr  <= m0_addr;
                     r_mem_wdata <= m0_wdata;
                  end
               end else begin
                  r_mem_we <= '0;
               end
            end

            ST_ACCESS: begin
               // Write enable is only ever asserted during ACCESS. Read data
               // is captured for the owner even on writes; the other
               // requester's rdata keeps its previous value.
               r_mem_we <= '0;
               if (r_owner) begin
                  r_m1_rdata <= mem_rdata;
                  r_m1_done  <= 1'b1;
               end else begin
                  r_m0_rdata <= mem_rdata;
                  r_m0_done  <= 1'b1;
               end
            end

            default: begin
               r_mem_we <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign mem_we    = r_mem_we;
   assign mem_size  = r_mem_size;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign m0_done   = r_m0_done;
   assign m1_done   = r_m1_done;
   assign m0_rdata  = r_m0_rdata;
   assign m1_rdata  = r_m1_rdata;
   assign owner     = r_owner;
   assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. Two instances share all inputs:
//   u_rr - round-robin (RR=1)
//   u_fp - fixed priority (RR=0)
// Each access takes three clock edges (grant, access, done); the bench
// checks owner, mem_* contents, the done pulse and the captured read data
// against values it derives from its own stimulus.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;

   logic          m0_req, m1_req, m1_lock;
   logic [1:0]    m0_we, m1_we;
   logic [2:0]    m0_size, m1_size;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [DW-1:0] mem_rdata;

   // Round-robin instance outputs
   logic          a_m0_done, a_m1_done, a_owner, a_busy;
   logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_mem_wdata;
   logic [1:0]    a_mem_we;
   logic [2:0]    a_mem_size;
   logic [AW-1:0] a_mem_addr;

   // Fixed-priority instance outputs
   logic          b_m0_done, b_m1_done, b_owner, b_busy;
   logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_mem_wdata;
   logic [1:0]    b_mem_we;
   logic [2:0]    b_mem_size;
   logic [AW-1:0] b_mem_addr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .RR(1'b1)) u_rr (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_done(a_m0_done), .m0_rdata(a_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_done(a_m1_done), .m1_rdata(a_m1_rdata),
      .m1_lock(m1_lock),
      .mem_we(a_mem_we), .mem_size(a_mem_size), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
      .owner(a_owner), .busy(a_busy)
   );

   dmem_arbiter #(.AW(AW), .DW(DW), .RR(1'b0)) u_fp (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_done(b_m0_done), .m0_rdata(b_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_done(b_m1_done), .m1_rdata(b_m1_rdata),
      .m1_lock(m1_lock),
      .mem_we(b_mem_we), .mem_size(b_mem_size), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
      .owner(b_owner), .busy(b_busy)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete access starting from IDLE with requests already driven.
   // wa/wb are the expected winners of the round-robin and fixed-priority
   // instances; rd is what memory returns during ACCESS.
   task automatic access(input string tag, input logic wa, input logic wb,
                         input logic [DW-1:0] rd);
      logic [1:0]    exp_we;
      logic [2:0]    exp_size;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata;
      exp_we    = wa ? m1_we    : m0_we;
      exp_size  = wa ? m1_size  : m0_size;
      exp_addr  = wa ? m1_addr  : m0_addr;
      exp_wdata = wa ? m1_wdata : m0_wdata;
      mem_rdata = rd;

      // Grant edge -> ACCESS cycle
      tick();
      check({tag, "_a_owner"}, 64'(a_owner), 64'(wa));
      check({tag, "_b_owner"}, 64'(b_owner), 64'(wb));
      check({tag, "_a_busy"},  64'(a_busy),  64'd1);
      check({tag, "_a_we"},    64'(a_mem_we),    64'(exp_we));
      check({tag, "_a_size"},  64'(a_mem_size),  64'(exp_size));
      check({tag, "_a_addr"},  64'(a_mem_addr),  64'(exp_addr));
      check({tag, "_a_wdata"}, 64'(a_mem_wdata), 64'(exp_wdata));
      check({tag, "_a_nodone"}, 64'({a_m1_done, a_m0_done}), 64'd0);

      // Access edge -> DONE cycle
      tick();
      check({tag, "_a_done"}, 64'({a_m1_done, a_m0_done}),
            wa ? 64'd2 : 64'd1);
      check({tag, "_b_done"}, 64'({b_m1_done, b_m0_done}),
            wb ? 64'd2 : 64'd1);
      check({tag, "_a_rdata"}, 64'(wa ? a_m1_rdata : a_m0_rdata), 64'(rd));
      check({tag, "_b_rdata"}, 64'(wb ? b_m1_rdata : b_m0_rdata), 64'(rd));
      check({tag, "_a_we_off"}, 64'(a_mem_we), 64'd0);

      // Done edge -> IDLE cycle
      tick();
      check({tag, "_a_done_off"}, 64'({a_m1_done, a_m0_done}), 64'd0);
      check({tag, "_a_idle"}, 64'(a_busy), 64'd0);
      check({tag, "_b_idle"}, 64'(b_busy), 64'd0);
   endtask

   initial begin
      reset    = 1'b1;
      m0_req   = 1'b0;  m1_req   = 1'b0;  m1_lock = 1'b0;
      m0_we    = 2'd0;  m1_we    = 2'd0;
      m0_size  = 3'd0;  m1_size  = 3'd0;
      m0_addr  = '0;    m1_addr  = '0;
      m0_wdata = '0;    m1_wdata = '0;
      mem_rdata = '0;

      // ---------------- Reset state ----------------
      tick();
      tick();
      check("rst_busy",  64'(a_busy),   64'd0);
      check("rst_owner", 64'(a_owner),  64'd0);
      check("rst_we",    64'(a_mem_we), 64'd0);
      check("rst_addr",  64'(a_mem_addr), 64'd0);
      check("rst_done",  64'({a_m1_done, a_m0_done}), 64'd0);
      check("rst_rdata", 64'(a_m0_rdata), 64'd0);
      reset = 1'b0;
      tick();
      check("idle_busy", 64'(a_busy), 64'd0);

      // ---------------- 1: M0 read only ----------------
      m0_req  = 1'b1;  m0_we = 2'd0;  m0_size = 3'd4;
      m0_addr = 32'h0000_0010;  m0_wdata = 32'h0;
      access("t1", 1'b0, 1'b0, 32'hDEAD_BEEF);
      m0_req = 1'b0;
      check("t1_m1_rdata_hold", 64'(a_m1_rdata), 64'd0);
      tick();
      check("t1_stay_idle", 64'(a_busy), 64'd0);

      // ---------------- 2: M1 write ----------------
      m1_req  = 1'b1;  m1_we = 2'd3;  m1_size = 3'd2;
      m1_addr = 32'h0000_0020;  m1_wdata = 32'h1234_5678;
      access("t2", 1'b1, 1'b1, 32'hA5A5_A5A5);
      m1_req = 1'b0;
      check("t2_m0_rdata_hold", 64'(a_m0_rdata), 64'hDEAD_BEEF);
      tick();
      check("t2_we_idle", 64'(a_mem_we), 64'd0);

      // ---------------- 3: both requesting from reset ----------------
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t3_owner_reset", 64'(a_owner), 64'd0);
      m0_we = 2'd0;  m1_we = 2'd0;
      m0_size = 3'd1;  m1_size = 3'd5;
      m0_addr = 32'h0000_0100;  m1_addr = 32'h0000_0200;
      m0_wdata = 32'h0000_00AA;  m1_wdata = 32'h0000_00BB;
      m0_req = 1'b1;  m1_req = 1'b1;
      // Round-robin alternates M1, M0, M1, M0; fixed priority stays on M1.
      access("t3_g0", 1'b1, 1'b1, 32'h0000_1000);
      access("t3_g1", 1'b0, 1'b1, 32'h0000_1001);
      access("t3_g2", 1'b1, 1'b1, 32'h0000_1002);
      access("t3_g3", 1'b0, 1'b1, 32'h0000_1003);

      // ---------------- 4: lock keeps M1 ----------------
      m1_lock = 1'b1;
      access("t4_g0", 1'b1, 1'b1, 32'h0000_2000);
      access("t4_g1", 1'b1, 1'b1, 32'h0000_2001);
      access("t4_g2", 1'b1, 1'b1, 32'h0000_2002);
      access("t4_g3", 1'b1, 1'b1, 32'h0000_2003);
      m1_lock = 1'b0;
      access("t4_unlock", 1'b0, 1'b1, 32'h0000_2004);

      // ---------------- 5: M0 only served when M1 is quiet ----------------
      access("t5_fp_m1", 1'b1, 1'b1, 32'h0000_3000);
      m1_req = 1'b0;
      access("t5_fp_m0", 1'b0, 1'b0, 32'h0000_3001);
      m0_req = 1'b0;
      tick();

      // ---------------- 6: reset during ACCESS ----------------
      m0_req = 1'b1;  m0_we = 2'd0;  m0_size = 3'd5;
      m0_addr = 32'h0000_0044;  m0_wdata = 32'h5555_0000;
      mem_rdata = 32'hCAFE_F00D;
      tick();
      check("t6_access_busy", 64'(a_busy), 64'd1);
      check("t6_access_size", 64'(a_mem_size), 64'd5);
      reset  = 1'b1;
      m0_req = 1'b0;
      tick();
      check("t6_busy",  64'(a_busy),      64'd0);
      check("t6_we",    64'(a_mem_we),    64'd0);
      check("t6_size",  64'(a_mem_size),  64'd0);
      check("t6_addr",  64'(a_mem_addr),  64'd0);
      check("t6_wdata", 64'(a_mem_wdata), 64'd0);
      check("t6_done",  64'({a_m1_done, a_m0_done}), 64'd0);
      check("t6_owner", 64'(a_owner),     64'd0);
      check("t6_rdata", 64'(a_m0_rdata),  64'd0);
      reset = 1'b0;
      tick();
      check("t6_no_done_1", 64'(a_m0_done), 64'd0);
      tick();
      check("t6_no_done_2", 64'(a_m0_done), 64'd0);
      check("t6_idle", 64'(a_busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: M0 = CPU load/store path, M1 = UART debug/loader path in the com controller.
- Sits between both requesters and dmem; memory-mapped I/O decoding stays downstream.
- Runs a fixed 3-state sequencer with round-robin or fixed-priority arbitration. A lock input lets M1 keep the port for multi-word debug transfers.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RR, 1, 1 = round-robin; 0 = fixed priority, M1 wins.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  CPU access request; held until m0_done.
- m0_we  in  2  CPU write size code (0 = read), passed to mem_we.
- m0_size  in  3  CPU load size/sign code, passed to mem_size.
- m0_addr  in  AW  CPU address.
- m0_wdata  in  DW  CPU write data.
- m0_done  out  1  one-cycle completion pulse.
- m0_rdata  out  DW  read data; valid when m0_done=1.
- m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_done, m1_rdata  same as M0, for the debug requester.
- m1_lock  in  1  while 1 with M1 as last owner, M1 keeps priority.
- mem_we  out  2  dmem write size code.
- mem_size  out  3  dmem load size code.
- mem_addr  out  AW  dmem address.
- mem_wdata  out  DW  dmem write data.
- mem_rdata  in  DW  dmem combinational read data.
- owner  out  1  last/current granted requester (0 = M0, 1 = M1).
- busy  out  1  1 when state is not IDLE.

Behaviour:
- Reset values (all registered outputs): state=IDLE, mem_we=0, mem_size=0, mem_addr=0, mem_wdata=0, m0_done=0, m1_done=0, m0_rdata=0, m1_rdata=0, owner=0, busy=0.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req=1, pick a winner and latch its we/size/addr/wdata into the mem_* registers.
  - Set owner=winner, go to ACCESS.
  - No request: stay in IDLE, mem_we=0.
- ACCESS (exactly one cycle):
  - mem_* outputs present the latched request; mem_we is nonzero only in this state.
  - At the clock edge, capture mem_rdata into the winner's rdata register.
  - Clear mem_we to 0 and go to DONE.
- DONE (one cycle):
  - Winner's done=1, other done=0.
  - Go to IDLE; a new grant can be latched on the next IDLE cycle.
- Latency: req seen at edge N -> ACCESS at N+1 -> done high in cycle N+2. Minimum 3 cycles per access per requester.
- Arbitration:
  - Only one requesting: it wins.
  - Both requesting, RR=1: the one not equal to owner wins.
  - Both requesting, RR=0: M1 wins.
  - Lock override (either RR): m1_lock=1 and owner=1 -> M1 wins.
- rdata of the non-winner holds its previous value. Writes still update the winner's rdata with mem_rdata (don't-care for the requester).
- Requester dropping req during ACCESS/DONE: the access still completes and the done pulse is still issued.
- Requester must deassert req in the cycle after done, or it is treated as a new request.
- Changes to m*_addr/wdata after the grant are ignored (latched at grant).
- Synchronous reset in any state returns to IDLE at the next edge with all reset values applied. A write in ACCESS at that edge is still presented for that cycle; no done is issued for an aborted transaction.
- owner changes only on a grant.
- busy = (state != IDLE), registered-equivalent.

Test Plan:
1. M0 only: m0_req=1, m0_we=0, addr=0x10, mem_rdata=0xDEADBEEF -> mem_addr=0x10 in ACCESS (N+1); m0_done=1 and m0_rdata=0xDEADBEEF at N+2; m1_done stays 0.
2. M1 write: m1_we=3, addr=0x20, wdata=0x12345678 -> mem_we=3 for exactly one cycle with that addr/wdata; m1_done pulses at N+2; mem_we=0 otherwise.
3. RR=1, both requesting continuously from reset (owner=0) -> grants alternate M1, M0, M1, M0; each done spaced 3 cycles apart.
4. RR=1, m1_lock=1 after an M1 grant, both requesting -> 4 consecutive M1 grants; lock drop -> next grant is M0.
5. RR=0, both requesting -> M1 always wins; M0 served only when m1_req=0.
6. reset asserted during ACCESS of an M0 read -> next cycle state=IDLE, busy=0, m0_done never pulses, all mem_* = 0.
